// File: rtl/queen_solution_sink.sv
// Captures an 8-queen solution one one-hot row per beat, exposes it packed, then streams
// it as ASCII digits plus a terminator. Optional board check: QUEEN_SINK_BOARD_CHECK_EN.
module queen_solution_sink #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned IDX_W     = 3,
  parameter logic [7:0]  TERM_CHAR = 8'h0A
) (
  input  logic                  clk,
  input  logic                  user_reset,
  input  logic                  sol_start,
  input  logic                  in_valid,
  input  logic [COLS-1:0]       in_row,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [ROWS*IDX_W-1:0] board_packed,
  output logic                  board_valid,
  output logic                  busy,
  output logic                  error,
  output logic                  conflict
);

  localparam int unsigned CNT_W = $clog2(ROWS + 1);

  typedef enum logic [2:0] {StIdle, StCapture, StCheck, StSend, StTerm} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]   send_cnt_q, send_cnt_d;
  logic [IDX_W-1:0]   idx_q [ROWS];
  logic [IDX_W-1:0]   idx_d [ROWS];
  logic               board_valid_q, board_valid_d;
  logic               error_q, error_d;

  logic [IDX_W-1:0]   enc_idx;
  logic               one_hot;
  logic [IDX_W-1:0]   send_idx;

  // Lowest set bit wins, so malformed rows still produce a deterministic index.
  always_comb begin
    enc_idx = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (in_row[c]) enc_idx = IDX_W'(c);
    end
    one_hot = (in_row != '0) && ((in_row & (in_row - COLS'(1))) == '0);
  end

  always_comb begin
    send_idx = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (send_cnt_q == CNT_W'(r)) send_idx = idx_q[r];
    end
  end

`ifdef QUEEN_SINK_BOARD_CHECK_EN
  logic [CNT_W-1:0]   check_cnt_q, check_cnt_d;
  logic               conflict_q, conflict_d;
  logic [IDX_W-1:0]   check_idx;
  logic signed [IDX_W:0] diff, adiff;
  logic               hit;

  // Row check_cnt_q against every earlier row: same column or same diagonal.
  always_comb begin
    check_idx = '0;
    hit       = 1'b0;
    diff      = '0;
    adiff     = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (check_cnt_q == CNT_W'(r)) check_idx = idx_q[r];
    end
    for (int j = 0; j < ROWS; j++) begin
      if (CNT_W'(j) < check_cnt_q) begin
        diff  = $signed({1'b0, check_idx}) - $signed({1'b0, idx_q[j]});
        adiff = (diff < 0) ? -diff : diff;
        if ((check_idx == idx_q[j]) || (int'(adiff) == int'(check_cnt_q) - j)) hit = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    row_cnt_d     = row_cnt_q;
    send_cnt_d    = send_cnt_q;
    idx_d         = idx_q;
    board_valid_d = board_valid_q;
    error_d       = error_q;
`ifdef QUEEN_SINK_BOARD_CHECK_EN
    check_cnt_d   = check_cnt_q;
    conflict_d    = conflict_q;
`endif

    // Beats arriving after the board is complete are overruns.
    if (in_valid && (state_q == StCheck || state_q == StSend || state_q == StTerm)) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (sol_start) begin
          state_d       = StCapture;
          row_cnt_d     = '0;
          error_d       = 1'b0;
          board_valid_d = 1'b0;
`ifdef QUEEN_SINK_BOARD_CHECK_EN
          conflict_d    = 1'b0;
`endif
        end
      end
      StCapture: begin
        if (sol_start) begin
          row_cnt_d = '0;
          error_d   = 1'b0;
        end else if (in_valid) begin
          for (int r = 0; r < ROWS; r++) begin
            if (row_cnt_q == CNT_W'(r)) idx_d[r] = enc_idx;
          end
          if (!one_hot) error_d = 1'b1;
          row_cnt_d = row_cnt_q + CNT_W'(1);
          if (row_cnt_q == CNT_W'(ROWS - 1)) begin
            board_valid_d = 1'b1;
            send_cnt_d    = '0;
`ifdef QUEEN_SINK_BOARD_CHECK_EN
            check_cnt_d   = '0;
            state_d       = StCheck;
`else
            state_d       = StSend;
`endif
          end
        end
      end
`ifdef QUEEN_SINK_BOARD_CHECK_EN
      StCheck: begin
        if (hit) conflict_d = 1'b1;
        check_cnt_d = check_cnt_q + CNT_W'(1);
        if (check_cnt_q == CNT_W'(ROWS - 1)) state_d = StSend;
      end
`endif
      StSend: begin
        if (out_ready) begin
          send_cnt_d = send_cnt_q + CNT_W'(1);
          if (send_cnt_q == CNT_W'(ROWS - 1)) state_d = StTerm;
        end
      end
      StTerm: begin
        if (out_ready) begin
          send_cnt_d = '0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (user_reset) begin
      state_q       <= StIdle;
      row_cnt_q     <= '0;
      send_cnt_q    <= '0;
      idx_q         <= '{default: '0};
      board_valid_q <= 1'b0;
      error_q       <= 1'b0;
`ifdef QUEEN_SINK_BOARD_CHECK_EN
      check_cnt_q   <= '0;
      conflict_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      row_cnt_q     <= row_cnt_d;
      send_cnt_q    <= send_cnt_d;
      idx_q         <= idx_d;
      board_valid_q <= board_valid_d;
      error_q       <= error_d;
`ifdef QUEEN_SINK_BOARD_CHECK_EN
      check_cnt_q   <= check_cnt_d;
      conflict_q    <= conflict_d;
`endif
    end
  end

  always_comb begin
    board_packed = '0;
    for (int r = 0; r < ROWS; r++) begin
      board_packed[r*IDX_W +: IDX_W] = idx_q[r];
    end
  end

  // Outputs decode registered state only, so out_ready never reaches out_valid.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    if (state_q == StSend) begin
      out_valid = 1'b1;
      out_data  = 8'h30 + {{(8 - IDX_W){1'b0}}, send_idx};
    end else if (state_q == StTerm) begin
      out_valid = 1'b1;
      out_data  = TERM_CHAR;
    end
  end

  assign board_valid = board_valid_q;
  assign busy        = (state_q != StIdle);
  assign error       = error_q;
`ifdef QUEEN_SINK_BOARD_CHECK_EN
  assign conflict    = conflict_q;
`else
  assign conflict    = 1'b0;
`endif

endmodule

// File: tb/tb_queen_solution_sink.sv
// Bench for queen_solution_sink: board-level model plus directed scenarios.
module tb_queen_solution_sink;

  logic        clk = 1'b0;
  logic        user_reset = 1'b1;
  logic        sol_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_row = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [23:0] board_packed;
  logic        board_valid;
  logic        busy;
  logic        error;
  logic        conflict;

  queen_solution_sink dut (
    .clk          (clk),
    .user_reset   (user_reset),
    .sol_start    (sol_start),
    .in_valid     (in_valid),
    .in_row       (in_row),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .board_packed (board_packed),
    .board_valid  (board_valid),
    .busy         (busy),
    .error        (error),
    .conflict     (conflict)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model of the board as the spec describes it.
  bit         running = 0;
  bit         m_cap = 0;
  int         m_cnt = 0;
  bit         m_err = 0;
  bit         m_bv = 0;
  bit         m_conf = 0;
  int         m_idx [8];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  function automatic int low_bit(input logic [7:0] r);
    for (int i = 0; i < 8; i++) if (r[i]) return i;
    return 0;
  endfunction

  function automatic logic [23:0] m_packed();
    logic [23:0] p = '0;
    for (int r = 0; r < 8; r++) p[r*3 +: 3] = m_idx[r][2:0];
    return p;
  endfunction

  function automatic bit m_queens_attack();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < i; j++) begin
        int d = m_idx[i] - m_idx[j];
        if (d < 0) d = -d;
        if (d == 0 || d == i - j) return 1;
      end
    return 0;
  endfunction

  task automatic m_start();
    m_cap = 1; m_cnt = 0; m_err = 0; m_bv = 0; m_conf = 0;
    got_q.delete();
  endtask

  task automatic m_beat(input logic [7:0] r);
    if (m_cap) begin
      m_idx[m_cnt] = low_bit(r);
      if ($countones(r) != 1) m_err = 1;
      m_cnt++;
      if (m_cnt == 8) begin
        m_cap = 0;
        m_bv  = 1;
        for (int k = 0; k < 8; k++) exp_q.push_back(8'h30 + 8'(m_idx[k]));
        exp_q.push_back(8'h0A);
        m_conf = m_queens_attack();
      end
    end else if (exp_q.size() > 0) begin
      m_err = 1;
    end
  endtask

  task automatic m_reset();
    m_cap = 0; m_cnt = 0; m_err = 0; m_bv = 0; m_conf = 0;
    for (int r = 0; r < 8; r++) m_idx[r] = 0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (running && !user_reset) begin
      chk("busy", busy, (m_cap || exp_q.size() > 0));
      chk("board_valid", board_valid, m_bv);
      chk("error", error, m_err);
      if (m_bv) chk("board_packed", board_packed, m_packed());
      if (out_valid) begin
        if (exp_q.size() == 0) chk("stray_out_valid", out_valid, 1'b0);
        else begin
          chk("out_data", out_data, exp_q[0]);
          if (out_ready) begin
            got_q.push_back(out_data);
            void'(exp_q.pop_front());
          end
        end
`ifdef QUEEN_SINK_BOARD_CHECK_EN
        chk("conflict", conflict, m_conf);
`endif
      end
`ifndef QUEEN_SINK_BOARD_CHECK_EN
      chk("conflict_tied", conflict, 1'b0);
`endif
    end
  end

  task automatic start_pulse();
    sol_start = 1; @(posedge clk); #1; sol_start = 0;
    m_start();
  endtask

  task automatic beat(input logic [7:0] r);
    in_valid = 1; in_row = r; @(posedge clk); #1; in_valid = 0; in_row = 8'h00;
    m_beat(r);
  endtask

  task automatic load(input logic [7:0] rows [8]);
    for (int i = 0; i < 8; i++) beat(rows[i]);
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    if (!out_valid) chk("wait_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic drain(input int mode);
    int cyc = 0;
    while (busy && cyc < 500) begin
      out_ready = (mode == 0) ? 1'b1 : (cyc % 4 == 0);
      @(posedge clk); #1; cyc++;
    end
    out_ready = 0;
    chk("drain_idle", busy, 1'b0);
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic chk_stream(input string name, input logic [7:0] ref_bytes [9]);
    chk({name, "_len"}, got_q.size(), 9);
    for (int k = 0; k < 9 && k < got_q.size(); k++) chk(name, got_q[k], ref_bytes[k]);
  endtask

  logic [7:0] good [8]   = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
  logic [7:0] bad [8]    = '{8'h00, 8'h10, 8'h80, 8'h24, 8'h04, 8'h40, 8'h02, 8'h08};
  logic [7:0] diag [8]   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] stream [9] = '{8'h30, 8'h34, 8'h37, 8'h35, 8'h32, 8'h36, 8'h31, 8'h33, 8'h0A};

  initial begin
    int n;
    m_reset();
    repeat (2) @(posedge clk);
    #1 user_reset = 0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_board_valid", board_valid, 1'b0);
    chk("rst_board_packed", board_packed, 24'h0);
    chk("rst_error", error, 1'b0);
    chk("rst_conflict", conflict, 1'b0);
    running = 1;

    // Stray beats in idle are ignored.
    in_valid = 1; in_row = 8'h03; @(posedge clk); #1; in_valid = 0;
    chk("idle_beat_error", error, 1'b0);

    // Valid board with latency check.
    start_pulse();
    load(good);
    wait_valid(n);
`ifdef QUEEN_SINK_BOARD_CHECK_EN
    chk("latency", n, 9);
`else
    chk("latency", n, 1);
`endif
    drain(0);
    chk("good_packed", board_packed, 24'o31625740);
    chk("good_board_valid", board_valid, 1'b1);
    chk("good_error", error, 1'b0);
    chk_stream("good_stream", stream);
`ifdef QUEEN_SINK_BOARD_CHECK_EN
    chk("good_conflict", conflict, 1'b0);
`endif

    // Backpressure: 1 cycle ready, 3 cycles not.
    start_pulse();
    load(good);
    drain(1);
    chk_stream("bp_stream", stream);

    // Malformed rows: zero and multi-bit.
    start_pulse();
    load(bad);
    drain(0);
    chk("bad_error", error, 1'b1);
    chk("bad_packed", board_packed, 24'o31622740);
    chk("bad_len", got_q.size(), 9);
    if (got_q.size() == 9) begin
      chk("bad_digit0", got_q[0], 8'h30);
      chk("bad_digit3", got_q[3], 8'h32);
    end

    // Restart mid-capture, then overrun during send.
    start_pulse();
    for (int i = 0; i < 4; i++) beat(8'h02);
    start_pulse();
    chk("restart_error", error, 1'b0);
    load(good);
    wait_valid(n);
    beat(8'h01);
    chk("overrun_error", error, 1'b1);
    drain(0);
    chk_stream("restart_stream", stream);
    chk("restart_packed", board_packed, 24'o31625740);

    // Reset after three bytes accepted.
    start_pulse();
    load(good);
    wait_valid(n);
    out_ready = 1;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 0;
    chk("pre_reset_bytes", got_q.size(), 3);
    user_reset = 1; @(posedge clk); #1; user_reset = 0;
    m_reset();
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_board_valid", board_valid, 1'b0);
    chk("mid_rst_board_packed", board_packed, 24'h0);
    repeat (3) begin @(posedge clk); #1; end
    chk("post_rst_out_valid", out_valid, 1'b0);

`ifdef QUEEN_SINK_BOARD_CHECK_EN
    start_pulse();
    load(diag);
    wait_valid(n);
    chk("diag_conflict", conflict, 1'b1);
    drain(0);
    chk("diag_conflict_held", conflict, 1'b1);
`else
    start_pulse();
    load(diag);
    drain(0);
    chk("diag_packed", board_packed, 24'o76543210);
`endif

    running = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
